ct_f_spsram_param: RTL and testbench
====================================

Name: ct_f_spsram_param

Overview:
- Parametrised single-port FPGA SRAM model that succeeds the fixed-size per-macro wrappers (for example the 256x7 variants).
- Keeps the macro's active-low CEN/GWEN/per-bit WEN interface.
- Adds three things the fixed wrappers lack:
  - a hardware init engine that clears the array after reset;
  - an optional output register stage;
  - defined Q hold behaviour.
- Sits under cache/TLB array wrappers in FPGA builds as the drop-in for any ct_f_spsram_<depth>x<width>.

Parameters:
- DATA_WIDTH, 7, word width in bits (1..256).
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words.
- OUT_REG, 0, 0 = read latency 1; 1 = extra output flop, read latency 2.
- INIT_EN, 1, 1 = clear array after reset; 0 = no init, array contents undefined.
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word during init.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST_B  in  1  reset, asynchronous assert, active-low.
- A  in  ADDR_WIDTH  word address.
- CEN  in  1  chip enable, active-low.
- GWEN  in  1  global write enable, active-low; 1 = read.
- WEN  in  DATA_WIDTH  per-bit write enable, active-low.
- D  in  DATA_WIDTH  write data.
- Q  out  DATA_WIDTH  read data.
- INIT_BUSY  out  1  high while the init engine owns the array.

Behaviour:
- Reset (RST_B=0):
  - Q=0, output pipeline flop=0, init counter=0.
  - FSM state = INIT if INIT_EN else READY.
  - INIT_BUSY = INIT_EN.
  - Array contents are not reset.
- FSM states: INIT, READY.
- INIT:
  - Each cycle writes INIT_VALUE to mem[cnt]; cnt increments.
  - When cnt = DEPTH-1 is written, go to READY next edge; INIT_BUSY drops that same edge.
  - Init takes exactly DEPTH cycles after RST_B deassertion.
  - User CEN is ignored (treated as 1) throughout INIT: no user writes, Q holds 0.
- Reset mid-INIT: async abort; restart from cnt=0 after release.
- READY: a user access occurs when CEN=0.
- Read (CEN=0, GWEN=1):
  - OUT_REG=0: Q = mem[A] after the next rising edge.
  - OUT_REG=1: Q = mem[A] one edge later (2 cycles).
  - Back-to-back reads are fully pipelined, one per cycle.
- Write (CEN=0, GWEN=0):
  - For each bit i with WEN[i]=0, mem[A][i] <= D[i].
  - Bits with WEN[i]=1 are unchanged.
  - WEN all ones means no bits change; the access still occurs and is not a read.
  - Q does not update on a write cycle: it holds the last read result.
  - With OUT_REG=1, an earlier read still emerges on schedule.
- Idle (CEN=1): Q holds the last read value indefinitely; the array is untouched.
- Read after write to the same address on the next cycle returns the newly written bits (no hazard; writes commit at the edge).
- Address wrap: A is taken modulo DEPTH; no out-of-range case exists.
- Storage: a behavioural reg array, inferable as block RAM (one synchronous read port, bit-masked write).
- Size: no width limits beyond DATA_WIDTH ≤ 256 and ADDR_WIDTH ≤ 16.

Test Plan:
- Init, default params: release RST_B, hold CEN=0/GWEN=0 with D=7'h7F during init.
  - INIT_BUSY high for exactly 256 cycles, then low.
  - Reading addresses 0, 128, 255 returns 7'h00; the user writes were ignored.
- Bit-masked write: write A=8'h3C, D=7'h7F, WEN=7'h00; then write D=7'h00, WEN=7'h55.
  - Read A=8'h3C returns 7'h55: cleared bits 1, 3, 5; kept bits 0, 2, 4, 6.
- Latency/hold, OUT_REG=0 then OUT_REG=1: write 7'h2A at A=5; read A=5; then CEN=1 for 10 cycles.
  - Q=7'h2A after 1 edge (OUT_REG=0) or 2 edges (OUT_REG=1).
  - Q stays 7'h2A through idle and through a later write to A=6.
- Back-to-back pipelining: write addresses 0..3 with 7'h11, 7'h22, 7'h33, 7'h44; then read 0..3 on consecutive cycles.
  - Q shows 7'h11, 7'h22, 7'h33, 7'h44 on consecutive cycles at the specified latency.
- Reset mid-init: assert RST_B low at init cycle 100 for 3 cycles.
  - Q=0 immediately (async).
  - After release, INIT_BUSY high for a full 256 cycles; all words equal INIT_VALUE.
- INIT_EN=0, DATA_WIDTH=32, ADDR_WIDTH=10: INIT_BUSY=0 from reset.
  - Write 32'hDEADBEEF at A=10'h3FF.
  - Read it back on the next cycle: Q=32'hDEADBEEF.

Source files
------------

// File: rtl/ct_f_spsram_param_if.sv
// Bus bundle for the parametrised single-port SRAM: macro-style active-low controls,
// read data and init status.
interface ct_f_spsram_param_if #(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [DATA_WIDTH-1:0] WEN;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;
  logic                  INIT_BUSY;

  modport master (output A, CEN, GWEN, WEN, D, input Q, INIT_BUSY);
  modport slave  (input A, CEN, GWEN, WEN, D, output Q, INIT_BUSY);
endinterface

// File: rtl/ct_f_spsram_param.sv
// Parametrised single-port SRAM with post-reset clear engine, optional output flop
// and read data that holds until the next read completes.
module ct_f_spsram_param #(
  parameter int                    DATA_WIDTH = 7,
  parameter int                    ADDR_WIDTH = 8,
  parameter bit                    OUT_REG    = 1'b0,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic                CLK,
  input logic                RST_B,
  ct_f_spsram_param_if.slave sram
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t RST_STATE = INIT_EN ? ST_INIT : ST_READY;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  w_we;
  logic                  w_re;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_wmask;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  // FSM, init counter and busy flag registers
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_busy  <= INIT_EN;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next state and write-port mux: init engine owns the port until the last word is cleared
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_waddr     = sram.A;
    w_wdata     = sram.D;
    w_wmask     = ~sram.WEN;
    case (r_state)
      ST_INIT: begin
        w_we      = 1'b1;
        w_waddr   = r_cnt;
        w_wdata   = INIT_VALUE;
        w_wmask   = '1;
        w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_READY;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_READY: begin
        w_we = !sram.CEN && !sram.GWEN;
        w_re = !sram.CEN && sram.GWEN;
      end
      default: begin
        w_state_nxt = RST_STATE;
      end
    endcase
    w_busy_nxt = (w_state_nxt == ST_INIT);
  end

  // Bit-masked write port; the array itself is never reset
  always_ff @(posedge CLK) begin
    if (w_we) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (w_wmask[i]) begin
          r_mem[w_waddr][i] <= w_wdata[i];
        end
      end
    end
  end

  generate
    if (OUT_REG) begin : g_oreg
      logic [DATA_WIDTH-1:0] r_pipe;
      logic                  r_pipe_vld;

      // Two-stage read: the valid bit lets an in-flight read land even if a write follows
      always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
          r_pipe     <= '0;
          r_pipe_vld <= 1'b0;
          r_q        <= '0;
        end else begin
          r_pipe_vld <= w_re;
          if (w_re) begin
            r_pipe <= r_mem[sram.A];
          end
          if (r_pipe_vld) begin
            r_q <= r_pipe;
          end
        end
      end
    end else begin : g_noreg
      // Single-stage read; Q only moves on a completed read
      always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
          r_q <= '0;
        end else if (w_re) begin
          r_q <= r_mem[sram.A];
        end
      end
    end
  endgenerate

  assign sram.Q         = r_q;
  assign sram.INIT_BUSY = r_busy;

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Bench for ct_f_spsram_param: three configurations checked against a word-level
// memory model every cycle, plus directed literal expectations.
module tb_ct_f_spsram_param;

  logic        clk = 1'b0;
  logic [2:0]  rst_b = 3'b111;
  logic [2:0]  cen;
  logic [2:0]  gwen;
  logic [9:0]  a   [3];
  logic [31:0] wen [3];
  logic [31:0] d   [3];
  logic [31:0] q   [3];
  logic [2:0]  busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ct_f_spsram_param_if #(.DATA_WIDTH(7),  .ADDR_WIDTH(8))  if0 ();
  ct_f_spsram_param_if #(.DATA_WIDTH(7),  .ADDR_WIDTH(8))  if1 ();
  ct_f_spsram_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) if2 ();

  ct_f_spsram_param #(.DATA_WIDTH(7), .ADDR_WIDTH(8), .OUT_REG(1'b0), .INIT_EN(1'b1),
                      .INIT_VALUE(7'h00))
    u_dut0 (.CLK(clk), .RST_B(rst_b[0]), .sram(if0));
  ct_f_spsram_param #(.DATA_WIDTH(7), .ADDR_WIDTH(8), .OUT_REG(1'b1), .INIT_EN(1'b1),
                      .INIT_VALUE(7'h00))
    u_dut1 (.CLK(clk), .RST_B(rst_b[1]), .sram(if1));
  ct_f_spsram_param #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .OUT_REG(1'b0), .INIT_EN(1'b0),
                      .INIT_VALUE(32'h0))
    u_dut2 (.CLK(clk), .RST_B(rst_b[2]), .sram(if2));

  assign if0.A = a[0][7:0];  assign if0.CEN = cen[0]; assign if0.GWEN = gwen[0];
  assign if0.WEN = wen[0][6:0]; assign if0.D = d[0][6:0];
  assign if1.A = a[1][7:0];  assign if1.CEN = cen[1]; assign if1.GWEN = gwen[1];
  assign if1.WEN = wen[1][6:0]; assign if1.D = d[1][6:0];
  assign if2.A = a[2];       assign if2.CEN = cen[2]; assign if2.GWEN = gwen[2];
  assign if2.WEN = wen[2];   assign if2.D = d[2];
  assign q[0] = {25'd0, if0.Q};
  assign q[1] = {25'd0, if1.Q};
  assign q[2] = if2.Q;
  assign busy = {if2.INIT_BUSY, if1.INIT_BUSY, if0.INIT_BUSY};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Word-level model: init countdown, array of words with known-flags, queue of reads in flight
  genvar k;
  for (k = 0; k < 3; k++) begin : g_m
    localparam int          DEP = (k == 2) ? 1024 : 256;
    localparam int          LAT = (k == 1) ? 2 : 1;
    localparam bit          IEN = (k != 2);
    localparam logic [31:0] WM  = (k == 2) ? 32'hFFFF_FFFF : 32'h0000_007F;
    typedef struct {
      int          due;
      logic [31:0] v;
      bit          ok;
    } rd_t;
    logic [31:0] mm [DEP];
    bit          mv [DEP];
    rd_t         pend [$];
    int          cyc = 0;
    int          init_left = IEN ? DEP : 0;
    logic [31:0] exp_q = 32'h0;
    bit          exp_q_vld = 1'b1;
    bit          exp_busy = IEN;

    initial begin
      for (int i = 0; i < DEP; i++) mv[i] = 1'b0;
      forever begin
        @(posedge clk or negedge rst_b[k]);
        if (!rst_b[k]) begin
          init_left = IEN ? DEP : 0;
          exp_q     = 32'h0;
          exp_q_vld = 1'b1;
          exp_busy  = IEN;
          pend.delete();
        end else begin
          int          ad;
          logic [31:0] ww;
          rd_t         e;
          cyc++;
          ad = int'(a[k]) % DEP;
          ww = wen[k] | ~WM;
          if (init_left > 0) begin
            mm[DEP - init_left] = 32'h0;
            mv[DEP - init_left] = 1'b1;
            init_left--;
          end else if (!cen[k]) begin
            if (!gwen[k]) begin
              mm[ad] = (mm[ad] & ww) | (d[k] & WM & ~ww);
              mv[ad] = mv[ad] || ((wen[k] & WM) == 32'h0);
            end else begin
              pend.push_back('{cyc + LAT - 1, mm[ad], mv[ad]});
            end
          end
          while (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            exp_q     = e.v;
            exp_q_vld = e.ok;
          end
          exp_busy = (init_left > 0);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (g_m[0].exp_q_vld) chk("model_q0", q[0], g_m[0].exp_q);
      if (g_m[1].exp_q_vld) chk("model_q1", q[1], g_m[1].exp_q);
      if (g_m[2].exp_q_vld) chk("model_q2", q[2], g_m[2].exp_q);
      chk("model_busy0", 32'(busy[0]), 32'(g_m[0].exp_busy));
      chk("model_busy1", 32'(busy[1]), 32'(g_m[1].exp_busy));
      chk("model_busy2", 32'(busy[2]), 32'(g_m[2].exp_busy));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Drive one access for exactly one rising edge, then leave that port idle
  task automatic op(input int p, input bit c, input bit g, input logic [9:0] ad,
                    input logic [31:0] w, input logic [31:0] dd);
    cen[p] = c; gwen[p] = g; a[p] = ad; wen[p] = w; d[p] = dd;
    @(negedge clk); #1;
    cen[p] = 1'b1; gwen[p] = 1'b1;
  endtask
  task automatic wr(input int p, input logic [9:0] ad, input logic [31:0] dd,
                    input logic [31:0] w);
    op(p, 1'b0, 1'b0, ad, w, dd);
  endtask
  task automatic rd(input int p, input logic [9:0] ad);
    op(p, 1'b0, 1'b1, ad, 32'hFFFF_FFFF, 32'h0);
  endtask
  task automatic idle(input int p);
    op(p, 1'b1, 1'b1, 10'h0, 32'hFFFF_FFFF, 32'h0);
  endtask

  logic [31:0] vals [4];
  int cnt;

  initial begin
    vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    cen = 3'b111; gwen = 3'b111;
    for (int i = 0; i < 3; i++) begin
      a[i] = 10'h0; wen[i] = 32'hFFFF_FFFF; d[i] = 32'h0;
    end
    #1 rst_b = 3'b000;
    @(negedge clk); #1;
    repeat (3) begin @(negedge clk); #1; end
    chk("reset_q0", q[0], 32'h0);
    chk("reset_q1", q[1], 32'h0);
    chk("reset_busy0", 32'(busy[0]), 32'h1);
    chk("reset_busy1", 32'(busy[1]), 32'h1);
    chk("reset_busy2", 32'(busy[2]), 32'h0);

    // Release and hammer user writes during init; they must be ignored
    rst_b = 3'b111;
    cnt = 0;
    while (busy[0] && cnt < 400) begin
      wr(0, 10'(cnt), 32'h7F, 32'h0);
      cnt++;
    end
    chk("init_cycles", 32'(cnt), 32'd256);
    chk("init_busy1_done", 32'(busy[1]), 32'h0);
    rd(0, 10'd0);   chk("init_rd0", q[0], 32'h0);
    rd(0, 10'd128); chk("init_rd128", q[0], 32'h0);
    rd(0, 10'd255); chk("init_rd255", q[0], 32'h0);

    // Bit-masked write
    wr(0, 10'h3C, 32'h7F, 32'h00);
    wr(0, 10'h3C, 32'h00, 32'h55);
    rd(0, 10'h3C);
    chk("bitmask_rd", q[0], 32'h55);

    // Latency and hold for both output modes
    for (int p = 0; p < 2; p++) begin
      wr(p, 10'd5, 32'h2A, 32'h0);
      rd(p, 10'd5);
      if (p == 0) chk("lat1_q", q[p], 32'h2A);
      else        chk("lat2_not_yet", q[p], 32'h0);
      wr(p, 10'd6, 32'h13, 32'h0);
      chk("q_after_write", q[p], 32'h2A);
      repeat (10) idle(p);
      chk("q_hold_idle", q[p], 32'h2A);
    end

    // Back-to-back reads
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) wr(p, 10'(i), vals[i], 32'h0);
      for (int j = 0; j < 4 + p; j++) begin
        if (j < 4) rd(p, 10'(j));
        else       idle(p);
        if (j - p >= 0) chk("b2b_q", q[p], vals[j - p]);
      end
    end

    // WEN all ones: access happens, nothing changes, Q does not update
    rd(0, 10'd6);
    chk("rd6", q[0], 32'h13);
    wr(0, 10'd6, 32'h00, 32'h7F);
    chk("wen_ones_q_hold", q[0], 32'h13);
    rd(0, 10'd6);
    chk("wen_ones_no_change", q[0], 32'h13);

    // No-init wide configuration
    wr(2, 10'h3FF, 32'hDEAD_BEEF, 32'h0);
    rd(2, 10'h3FF);
    chk("wide_rd", q[2], 32'hDEAD_BEEF);
    wr(2, 10'h3FF, 32'h0, 32'hFFFF_0000);
    rd(2, 10'h3FF);
    chk("wide_mask_rd", q[2], 32'hDEAD_0000);

    // Async reset from READY, then abort an init at cycle 100
    rst_b[0] = 1'b0;
    #1 chk("async_q_clear", q[0], 32'h0);
    repeat (3) begin @(negedge clk); #1; end
    rst_b[0] = 1'b1;
    for (int i = 0; i < 100; i++) wr(0, 10'(i), 32'h7F, 32'h0);
    chk("midinit_busy", 32'(busy[0]), 32'h1);
    rst_b[0] = 1'b0;
    #1 chk("midinit_async_q", q[0], 32'h0);
    repeat (3) begin @(negedge clk); #1; end
    rst_b[0] = 1'b1;
    cnt = 0;
    while (busy[0] && cnt < 400) begin
      idle(0);
      cnt++;
    end
    chk("reinit_cycles", 32'(cnt), 32'd256);
    for (int i = 0; i < 256; i++) rd(0, 10'(i));
    rd(0, 10'h3C);
    chk("reinit_3c", q[0], 32'h0);
    rd(0, 10'd3);
    chk("reinit_3", q[0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
